// File: rtl/serial_to_parallel.sv
// LSB-first serial-to-parallel converter with a valid/ready output stage.
// Define S2P_BUF_EN for a 2-entry output FIFO instead of a holding register.
module serial_to_parallel #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_data,
    input  logic             s_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] p_data,
    output logic             p_valid,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CW-1:0]    bit_cnt;
    logic [CW-1:0]    cnt_nx;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] word_nx;
    logic             done;
    logic             trunc;
    logic             pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            word      <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nx;
            bit_cnt   <= cnt_nx;
            word      <= word_nx;
            frame_err <= trunc;
        end
    end

    // word_nx is the completed word on the edge where done is high
    always_comb begin
        state_nx = state;
        cnt_nx   = bit_cnt;
        word_nx  = word;
        done     = 1'b0;
        trunc    = 1'b0;
        unique case (state)
            IDLE: begin
                if (s_valid) begin
                    word_nx    = '0;
                    word_nx[0] = s_data;
                    cnt_nx     = CW'(1);
                    state_nx   = SHIFT;
                end
            end
            SHIFT: begin
                if (!s_valid) begin
                    trunc    = 1'b1;
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else begin
                    word_nx[bit_cnt] = s_data;
                    if (bit_cnt == LAST) begin
                        done     = 1'b1;
                        cnt_nx   = '0;
                        state_nx = IDLE;
                    end else begin
                        cnt_nx = bit_cnt + CW'(1);
                    end
                end
            end
        endcase
    end

    assign busy = (state == SHIFT);
    assign pop  = p_valid & out_ready;

`ifdef S2P_BUF_EN
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic [1:0]       count;

    assign p_valid = (count != 2'd0);
    assign p_data  = head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count   <= 2'd0;
            overrun <= 1'b0;
        end else begin
            overrun <= 1'b0;
            unique case ({done, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head  <= word_nx;
                        count <= 2'd1;
                    end else if (count == 2'd1) begin
                        tail  <= word_nx;
                        count <= 2'd2;
                    end else begin
                        overrun <= 1'b1;
                    end
                end
                2'b01: begin
                    if (count == 2'd2) head <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= word_nx;
                    end else begin
                        head <= tail;
                        tail <= word_nx;
                    end
                end
                default: ;
            endcase
        end
    end
`else
    logic [WIDTH-1:0] hold;
    logic             hold_vld;

    assign p_valid = hold_vld;
    assign p_data  = hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold     <= '0;
            hold_vld <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done) begin
                if (!hold_vld || pop) begin
                    hold     <= word_nx;
                    hold_vld <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (pop) begin
                hold_vld <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_serial_to_parallel.sv
// Directed table-driven bench for serial_to_parallel (WIDTH=4).
// Expected values follow the S2P_BUF_EN setting of the build.
module tb_serial_to_parallel;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_data = 1'b0;
    logic       s_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [3:0] p_data;
    logic       p_valid;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic       v;
        logic       d;
        logic       r;
        logic       pv;
        logic [3:0] pd;
        logic       bz;
        logic       fe;
        logic       ov;
    } vec_t;

    vec_t tbl[$];

    serial_to_parallel #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .out_ready (out_ready),
        .p_data    (p_data),
        .p_valid   (p_valid),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic add(input logic v, input logic d, input logic r,
                       input logic pv, input logic [3:0] pd,
                       input logic bz, input logic fe, input logic ov);
        vec_t e;
        e.v = v; e.d = d; e.r = r;
        e.pv = pv; e.pd = pd; e.bz = bz; e.fe = fe; e.ov = ov;
        tbl.push_back(e);
    endtask

    task automatic chk(input string name, input logic [7:0] exp);
        logic [7:0] got;
        got = {p_valid, p_data, busy, frame_err, overrun};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got pv/pd/busy/fe/ov=%b_%h_%b%b%b want %b_%h_%b%b%b",
                     name, got[7], got[6:3], got[2], got[1], got[0],
                     exp[7], exp[6:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic step(input logic v, input logic d, input logic r);
        s_valid = v;
        s_data = d;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] pd0;

    initial begin
        // 026: single word 4'hD
        add(1,1,1, 0,4'h0,1,0,0);
        add(1,0,1, 0,4'h0,1,0,0);
        add(1,1,1, 0,4'h0,1,0,0);
        add(1,1,1, 1,4'hD,0,0,0);
        add(0,0,1, 0,4'hD,0,0,0);
        // 027: back-to-back 4'h3 then 4'hA
        add(1,1,1, 0,4'hD,1,0,0);
        add(1,1,1, 0,4'hD,1,0,0);
        add(1,0,1, 0,4'hD,1,0,0);
        add(1,0,1, 1,4'h3,0,0,0);
        add(1,0,1, 0,4'h3,1,0,0);
        add(1,1,1, 0,4'h3,1,0,0);
        add(1,0,1, 0,4'h3,1,0,0);
        add(1,1,1, 1,4'hA,0,0,0);
        add(0,0,1, 0,4'hA,0,0,0);
        // 028: truncation
        add(1,1,1, 0,4'hA,1,0,0);
        add(1,1,1, 0,4'hA,1,0,0);
        add(0,0,1, 0,4'hA,0,1,0);
        add(0,0,1, 0,4'hA,0,0,0);
        // 029: backpressure, words 1, 2, 4
        add(1,1,0, 0,4'hA,1,0,0);
        add(1,0,0, 0,4'hA,1,0,0);
        add(1,0,0, 0,4'hA,1,0,0);
        add(1,0,0, 1,4'h1,0,0,0);
        add(1,0,0, 1,4'h1,1,0,0);
        add(1,1,0, 1,4'h1,1,0,0);
        add(1,0,0, 1,4'h1,1,0,0);
`ifdef S2P_BUF_EN
        add(1,0,0, 1,4'h1,0,0,0);
`else
        add(1,0,0, 1,4'h1,0,0,1);
`endif
        add(1,0,0, 1,4'h1,1,0,0);
        add(1,0,0, 1,4'h1,1,0,0);
        add(1,1,0, 1,4'h1,1,0,0);
        add(1,0,0, 1,4'h1,0,0,1);
        add(0,0,0, 1,4'h1,0,0,0);
`ifdef S2P_BUF_EN
        add(0,0,1, 1,4'h2,0,0,0);
        add(0,0,1, 0,4'h2,0,0,0);
        pd0 = 4'h2;
`else
        add(0,0,1, 0,4'h1,0,0,0);
        add(0,0,1, 0,4'h1,0,0,0);
        pd0 = 4'h1;
`endif
        // 031: full stage, pop on the completion edge
        add(1,1,0, 0,pd0,1,0,0);
        add(1,0,0, 0,pd0,1,0,0);
        add(1,1,0, 0,pd0,1,0,0);
        add(1,0,0, 1,4'h5,0,0,0);
`ifdef S2P_BUF_EN
        add(1,1,0, 1,4'h5,1,0,0);
        add(1,0,0, 1,4'h5,1,0,0);
        add(1,0,0, 1,4'h5,1,0,0);
        add(1,1,0, 1,4'h5,0,0,0);
        add(1,0,0, 1,4'h5,1,0,0);
        add(1,0,0, 1,4'h5,1,0,0);
        add(1,1,0, 1,4'h5,1,0,0);
        add(1,1,1, 1,4'h9,0,0,0);
        add(0,0,1, 1,4'hC,0,0,0);
        add(0,0,1, 0,4'hC,0,0,0);
`else
        add(1,0,0, 1,4'h5,1,0,0);
        add(1,0,0, 1,4'h5,1,0,0);
        add(1,1,0, 1,4'h5,1,0,0);
        add(1,1,1, 1,4'hC,0,0,0);
        add(0,0,1, 0,4'hC,0,0,0);
`endif

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 8'h00);
        rst = 1'b0;

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].d, tbl[i].r);
            chk($sformatf("row%0d", i),
                {tbl[i].pv, tbl[i].pd, tbl[i].bz, tbl[i].fe, tbl[i].ov});
        end

        // 030: reset mid-word with a buffered word present
        step(1,1,0); step(1,1,0); step(1,1,0); step(1,0,0);
        chk("pre_rst_word", {1'b1, 4'h7, 3'b000});
        step(1,1,0); step(1,1,0); step(1,1,0);
        chk("pre_rst_busy", {1'b1, 4'h7, 3'b100});
        rst = 1'b1;
        #2;
        chk("rst_async", 8'h00);
        step(1,1,0);
        chk("rst_held", 8'h00);
        rst = 1'b0;
        step(1,0,0);
        chk("post_rst_b0", {1'b0, 4'h0, 3'b100});
        step(1,1,0);
        chk("post_rst_b1", {1'b0, 4'h0, 3'b100});
        step(1,1,0);
        chk("post_rst_b2", {1'b0, 4'h0, 3'b100});
        step(1,0,0);
        chk("post_rst_word", {1'b1, 4'h6, 3'b000});
        step(0,0,1);
        chk("post_rst_pop", {1'b0, 4'h6, 3'b000});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_to_parallel.md
SERIAL_TO_PARALLEL -- requirements
Module: serial_to_parallel

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the word width in bits; legal range is 2 to 16.
REQ-002 The block SHALL have port clk, input, 1 bit, the clock; all state changes on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, the reset: asynchronous, active-high.
REQ-004 The block SHALL have port s_data, input, 1 bit, the serial data bit, LSB first.
REQ-005 The block SHALL have port s_valid, input, 1 bit, qualifying s_data; high for WIDTH consecutive cycles per word.
REQ-006 The block SHALL have port out_ready, input, 1 bit, the downstream consumer ready.
REQ-007 The block SHALL have port p_data, output, WIDTH bits, the assembled parallel word.
REQ-008 The block SHALL have port p_valid, output, 1 bit, meaning p_data holds an unconsumed word.
REQ-009 The block SHALL have port busy, output, 1 bit, high while a word is partially received (1 to WIDTH-1 bits captured).
REQ-010 The block SHALL have port frame_err, output, 1 bit, a one-cycle pulse on a truncated word.
REQ-011 The block SHALL have port overrun, output, 1 bit, a one-cycle pulse when a completed word is dropped.

Function
REQ-012 The block SHALL sample s_data on every rising edge where s_valid=1; a cycle with s_valid=0 SHALL capture nothing.
REQ-013 The block SHALL place bit k of a word (k = 0 first) into position k of the assembled word.
REQ-014 The receive FSM SHALL have exactly two states:
- IDLE (bit_cnt=0).
- SHIFT (bit_cnt 1..WIDTH-1).
- IDLE goes to SHIFT on the first valid bit.
- SHIFT returns to IDLE on the WIDTH-th valid bit, or when s_valid=0.
REQ-015 On the edge sampling the WIDTH-th bit, the block SHALL push the word to the output stage; p_valid SHALL be high in the next cycle (latency 1 cycle from the last bit).
REQ-016 If s_valid stays high after the WIDTH-th bit, the next sampled bit SHALL be bit 0 of a new word, with no idle cycle required.
REQ-017 If s_valid is low while in SHIFT, the block SHALL:
- discard the partial word;
- pulse frame_err for one cycle;
- return to IDLE, with p_valid unaffected.
REQ-018 A word SHALL leave the output stage on any edge where p_valid=1 and out_ready=1; p_data SHALL remain stable while p_valid=1 and out_ready=0.
REQ-019 A completed word arriving when the output stage is full SHALL be dropped, and overrun SHALL pulse for one cycle; stored words SHALL be unchanged.
REQ-020 When a word completes in the same cycle that the output stage is full and a pop occurs, the new word SHALL be accepted and overrun SHALL NOT pulse.
REQ-021 The block SHALL drive busy=1 exactly while the FSM is in SHIFT.

Reset
REQ-022 While rst=1, the block SHALL hold:
- FSM in IDLE, bit_cnt=0;
- output stage empty;
- p_data=0, p_valid=0, busy=0, frame_err=0, overrun=0.
REQ-023 Reset asserted mid-word SHALL discard the partial word and all buffered words without pulsing frame_err; reception SHALL restart with the first s_valid=1 cycle after rst falls.

Configuration
REQ-024 Macro S2P_BUF_EN defined SHALL make the output stage a 2-entry FIFO:
- p_data shows the oldest entry;
- overrun occurs only when both entries are full and no pop occurs.
REQ-025 Macro S2P_BUF_EN undefined SHALL make the output stage a single holding register:
- overrun occurs when p_valid=1, out_ready=0 and a word completes.

Verification
REQ-026 The bench SHALL cover a single word: WIDTH=4, bits 1,0,1,1 on 4 valid cycles, out_ready=1 -> p_data=4'hD and p_valid=1 for one cycle, starting 1 cycle after the 4th bit.
REQ-027 The bench SHALL cover back-to-back words: s_valid high for 8 cycles carrying 4'h3 then 4'hA, out_ready=1 -> p_data 4'h3 then 4'hA, no frame_err.
REQ-028 The bench SHALL cover truncation: 2 valid bits then s_valid=0 -> frame_err pulses 1 cycle, busy falls, p_valid stays 0.
REQ-029 The bench SHALL cover backpressure with out_ready=0 and words 4'h1, 4'h2, 4'h4 sent:
- buffer build: p_data=4'h1, overrun on the third word;
- no-buffer build: p_data=4'h1, overrun on the second word.
REQ-030 The bench SHALL cover reset after 3 bits: rst pulse mid-word, then a full word 4'h6 -> outputs 0 during reset, then p_data=4'h6, no frame_err.
REQ-031 The bench SHALL cover simultaneous pop and completion: output stage full, out_ready=1 on the completion edge -> new word accepted, no overrun.
